// File: rtl/shift_normalizer_if.sv
// Handshake bundle between a producer of operands and the shift_normalizer.
// The master side offers operands and consumes results; the slave side is
// the normalizer itself.
interface shift_normalizer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_signed;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0]  out_count;
    logic                  out_zero;

    modport master (
        output in_valid, in_data, in_signed, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_signed, out_ready,
        output in_ready, out_valid, out_data, out_count, out_zero
    );
endinterface

// File: rtl/shift_normalizer.sv
// Multi-cycle normalizer: shifts an operand left one bit per cycle until it is
// normalized (unsigned: MSB set; signed: top two bits differ) and reports the
// normalized value together with the number of shifts applied.
module shift_normalizer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic               clk,
    input  logic               rst,
    shift_normalizer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [DATA_WIDTH-1:0] work;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  sgn;
    logic                  stop;
    logic                  accept;
    logic                  release_res;

    logic [DATA_WIDTH-1:0] res_data;
    logic [CNT_WIDTH-1:0]  res_count;
    logic                  res_zero;

    assign accept      = bus.in_valid  && bus.in_ready;
    assign release_res = bus.out_valid && bus.out_ready;

    // Normalization reached: MSB set (unsigned) or sign bit differs from the next bit (signed).
    always_comb begin
        stop = work[DATA_WIDTH-1];
        if (sgn) begin
            stop = work[DATA_WIDTH-1] ^ work[DATA_WIDTH-2];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: defaulting the next state up front keeps this block free of
        // inferred latches on paths that do not change state.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (bus.in_data == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (stop) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (release_res) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded purely from the current state.
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
    end

    // Working register, shift counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            work      <= '0;
            cnt       <= '0;
            sgn       <= 1'b0;
            res_data  <= '0;
            res_count <= '0;
            res_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        work <= bus.in_data;
                        sgn  <= bus.in_signed;
                        cnt  <= '0;
                        if (bus.in_data == '0) begin
                            res_data  <= '0;
                            res_count <= '0;
                            res_zero  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    // A nonzero operand always stops by count W-1, so the counter cannot wrap.
                    if (stop) begin
                        res_data  <= work;
                        res_count <= cnt;
                        res_zero  <= 1'b0;
                    end else begin
                        work <= work << 1;
                        cnt  <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.out_data  = res_data;
    assign bus.out_count = res_count;
    assign bus.out_zero  = res_zero;

endmodule
